// File: rtl/acc_req_buffer.sv
// rtl/acc_req_buffer.sv - per-accumulator request FIFOs between core commit and FPR accumulators
module acc_req_buffer #(
  parameter int N_ACC = 3,
  parameter int DEPTH = 4,
  localparam int AW = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [AW-1:0]           push_acc,
  input  logic [31:0]             push_data,
  output logic                    push_ready,
  output logic [N_ACC-1:0]        acc_req_valid,
  output logic [N_ACC-1:0][31:0]  acc_data,
  input  logic [N_ACC-1:0]        acc_req_ready,
  output logic                    busy,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem   [N_ACC][DEPTH];
  logic [PW-1:0] r_rd    [N_ACC];
  logic [PW-1:0] r_wr    [N_ACC];
  logic [CW-1:0] r_count [N_ACC];
  logic          r_overflow;

  logic [N_ACC-1:0] w_push_en;
  logic [N_ACC-1:0] w_pop;

  // Acceptance looks only at the registered count, so a full channel stays
  // closed even when it pops this cycle; out-of-range indices never match.
  always_comb begin
    push_ready = 1'b0;
    for (int i = 0; i < N_ACC; i++) begin
      if (push_acc == AW'(i)) begin
        push_ready = (r_count[i] != CW'(DEPTH));
      end
    end
  end

  // Per-channel push and pop enables.
  always_comb begin
    w_push_en = '0;
    w_pop     = '0;
    for (int i = 0; i < N_ACC; i++) begin
      w_push_en[i] = push && (push_acc == AW'(i)) && (r_count[i] != CW'(DEPTH));
      w_pop[i]     = (r_count[i] != '0) && acc_req_ready[i];
    end
  end

  // Head-of-queue outputs come straight from registered state (no empty bypass).
  always_comb begin
    acc_req_valid = '0;
    acc_data      = '0;
    for (int i = 0; i < N_ACC; i++) begin
      acc_req_valid[i] = (r_count[i] != '0);
      acc_data[i]      = r_mem[i][r_rd[i]];
    end
    busy     = |acc_req_valid;
    overflow = r_overflow;
  end

  // Pointers, occupancy and the sticky overflow flag; reset wins over traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ACC; i++) begin
        r_rd[i]    <= '0;
        r_wr[i]    <= '0;
        r_count[i] <= '0;
      end
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_ACC; i++) begin
        if (w_push_en[i]) begin
          r_wr[i] <= r_wr[i] + PW'(1);
        end
        if (w_pop[i]) begin
          r_rd[i] <= r_rd[i] + PW'(1);
        end
        case ({w_push_en[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
      if (push && !push_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage is left uninitialised; only the pointers define its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ACC; i++) begin
      if (w_push_en[i] && !reset) begin
        r_mem[i][r_wr[i]] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_acc_req_buffer.sv
// tb/tb_acc_req_buffer.sv - scoreboard bench for acc_req_buffer
module tb_acc_req_buffer;

  localparam int N = 3;
  localparam int D = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [1:0]        push_acc;
  logic [31:0]       push_data;
  logic              push_ready;
  logic [N-1:0]      acc_req_valid;
  logic [N-1:0][31:0] acc_data;
  logic [N-1:0]      acc_req_ready;
  logic              busy;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb [N][$];
  bit          m_ovf;

  acc_req_buffer #(.N_ACC(N), .DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_acc      (push_acc),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .acc_req_valid (acc_req_valid),
    .acc_data      (acc_data),
    .acc_req_ready (acc_req_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit p, input logic [1:0] a,
                       input logic [31:0] d, input logic [N-1:0] rdy);
    bit exp_rdy;
    bit any;
    reset = rst;
    push = p;
    push_acc = a;
    push_data = d;
    acc_req_ready = rdy;
    #1;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), {31'd0, acc_req_valid[i]}, {31'd0, sb[i].size() != 0});
      if (sb[i].size() != 0) begin
        chk($sformatf("data%0d", i), acc_data[i], sb[i][0]);
        any = 1'b1;
      end
    end
    exp_rdy = 1'b0;
    if (a < N) exp_rdy = (sb[a].size() < D);
    chk($sformatf("push_ready_acc%0d", a), {31'd0, push_ready}, {31'd0, exp_rdy});
    chk("busy", {31'd0, busy}, {31'd0, any});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (rst) begin
      for (int i = 0; i < N; i++) sb[i].delete();
      m_ovf = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sb[i].size() != 0 && rdy[i]) void'(sb[i].pop_front());
      end
      if (p && exp_rdy) sb[a].push_back(d);
      if (p && !exp_rdy) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    push_acc = '0;
    push_data = '0;
    acc_req_ready = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // post-reset state, push_ready for every valid channel
    for (int a = 0; a < N; a++) cycle(0, 0, 2'(a), 32'h0, '1);

    // single push to channel 1, one-cycle latency, popped next cycle
    cycle(0, 1, 2'd1, 32'h3F800000, 3'b111);
    cycle(0, 0, 2'd0, 32'h0, 3'b111);
    cycle(0, 0, 2'd0, 32'h0, 3'b111);

    // fill channel 0 with ready[0] low, full/not-full readiness, fifth push overflows
    cycle(0, 1, 2'd0, 32'h3F800000, 3'b110);
    cycle(0, 1, 2'd0, 32'h40000000, 3'b110);
    cycle(0, 1, 2'd0, 32'h40400000, 3'b110);
    cycle(0, 1, 2'd0, 32'h40800000, 3'b110);
    cycle(0, 0, 2'd0, 32'h0, 3'b110);
    cycle(0, 0, 2'd2, 32'h0, 3'b110);
    cycle(0, 1, 2'd0, 32'hDEADBEEF, 3'b110);
    for (int k = 0; k < 5; k++) cycle(0, 0, 2'd0, 32'h0, 3'b111);

    // full channel popping in the same cycle still rejects the push
    cycle(1, 0, 2'd0, 32'h0, 3'b000);
    for (int k = 0; k < D; k++) cycle(0, 1, 2'd0, 32'h1000 + k, 3'b000);
    cycle(0, 1, 2'd0, 32'hBAD0BAD0, 3'b111);
    for (int k = 0; k < D; k++) cycle(0, 0, 2'd0, 32'h0, 3'b111);

    // alternating channels with all ready, concurrent pops on different channels
    cycle(1, 0, 2'd0, 32'h0, 3'b000);
    for (int k = 0; k < 9; k++) cycle(0, 1, 2'(k % 3), 32'h2000 + k, 3'b111);
    cycle(0, 0, 2'd0, 32'h0, 3'b111);
    cycle(0, 0, 2'd0, 32'h0, 3'b111);

    // channel 2 held with two entries, then released; then pointer wrap
    cycle(0, 1, 2'd2, 32'h3000, 3'b011);
    cycle(0, 1, 2'd2, 32'h3001, 3'b011);
    for (int k = 0; k < 5; k++) cycle(0, 0, 2'd0, 32'h0, 3'b011);
    for (int k = 0; k < 3; k++) cycle(0, 0, 2'd0, 32'h0, 3'b111);
    for (int k = 0; k < 2 * D; k++) cycle(0, 1, 2'd2, 32'h4000 + k, {(k % 3) != 0, 2'b11});
    for (int k = 0; k < 2 * D; k++) cycle(0, 0, 2'd0, 32'h0, 3'b111);

    // out-of-range index overflows, then reset with entries queued and push active
    cycle(0, 1, 2'd3, 32'h5555, 3'b000);
    cycle(0, 1, 2'd0, 32'h6000, 3'b000);
    cycle(0, 1, 2'd1, 32'h6001, 3'b000);
    cycle(0, 1, 2'd2, 32'h6002, 3'b000);
    cycle(1, 1, 2'd0, 32'h6003, 3'b111);
    for (int a = 0; a < N; a++) cycle(0, 0, 2'(a), 32'h0, '1);

    // random traffic against the scoreboard
    for (int k = 0; k < 300; k++) begin
      cycle(0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            $urandom, 3'($urandom_range(0, 7)));
    end
    for (int k = 0; k < 2 * D; k++) cycle(0, 0, 2'd0, 32'h0, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
